// File: rtl/ufm_host_link_master.sv
// ---------------------------------------------------------------------------
// ufm_host_link_master
//
// Host-side initiator of the miner-FPGA byte link. Serialises one work unit
// (midstate + data) into IN_BYTES byte strobes on read/rd_clk. Reads back one
// result of OUT_BYTES bytes using wr_start/wr_clk, sampling the write bus.
//
// rd_clk and wr_clk are level-toggle strobes. Every edge of either one moves
// one byte. They keep their level between transfers, and only reset clears
// them.
//
// Ports
//   clk         single clock
//   reset       synchronous reset, active-high; aborts any transfer
//   work_valid  work word offered (hold until work_ready)
//   work_data   {midstate, data}; bits [7:0] go out first
//   work_ready  one-cycle pulse: work word accepted
//   rd_req      result readback requested (hold until rd_ack)
//   rd_ack      one-cycle pulse: readback accepted
//   res_valid   result word held valid until res_valid & res_ready
//   res_data    result; first byte received lands in [7:0]
//   res_ready   result consumed
//   busy        FSM not in IDLE
//   select      link select, high whenever not in IDLE
//   rd_clk      write strobe to slave (toggle per byte)
//   read        byte to slave, 0 in IDLE
//   wr_start    readback latch request
//   wr_clk      readback shift strobe (toggle per byte)
//   write       byte from slave
// ---------------------------------------------------------------------------
module ufm_host_link_master #(
    parameter int STEP      = 4,   // clk cycles per half-strobe, >= 4
    parameter int SETTLE    = 16,  // clk cycles before sampling write, >= 10
    parameter int IN_BYTES  = 44,
    parameter int OUT_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   work_valid,
    input  logic [IN_BYTES*8-1:0]  work_data,
    output logic                   work_ready,
    input  logic                   rd_req,
    output logic                   rd_ack,
    output logic                   res_valid,
    output logic [OUT_BYTES*8-1:0] res_data,
    input  logic                   res_ready,
    output logic                   busy,
    output logic                   select,
    output logic                   rd_clk,
    output logic [7:0]             read,
    output logic                   wr_start,
    output logic                   wr_clk,
    input  logic [7:0]             write
);

    localparam int IN_W  = IN_BYTES * 8;
    localparam int OUT_W = OUT_BYTES * 8;

    localparam logic [4:0] STEP_LAST   = 5'(STEP - 1);
    localparam logic [4:0] START_LAST  = 5'(2 * STEP - 1);
    localparam logic [4:0] SETTLE_LAST = 5'(SETTLE - 1);
    localparam logic [5:0] IN_LAST     = 6'(IN_BYTES - 1);
    localparam logic [5:0] OUT_LAST    = 6'(OUT_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        R_START,
        R_SETTLE,
        R_SAMPLE
    } state_t;

    state_t          state;
    logic [4:0]      step_cnt;   // step / settle counter
    logic [5:0]      byte_cnt;   // bytes done in the current transfer
    logic [IN_W-1:0] shreg;

    logic accept_work;
    logic accept_rd;

    // A write is held off only while a result sits unread and a readback is
    // also pending. A readback needs the result slot free. A slot that is
    // consumed in this same cycle counts as free.
    assign accept_work = (state == IDLE) && work_valid && (!res_valid || !rd_req);
    assign accept_rd   = (state == IDLE) && rd_req && !work_valid &&
                         (!res_valid || res_ready);

    // NOTE: the work shift register is pure datapath. It is loaded on every
    // acceptance, and read only after that load, so it has no reset. This
    // keeps the reset net off 352 flops.
    always_ff @(posedge clk) begin
        if (accept_work) begin
            shreg <= work_data;
        end else if (state == W_STROBE && step_cnt == STEP_LAST) begin
            shreg <= {8'h00, shreg[IN_W-1:8]};
        end
    end

    // NOTE: all state and outputs use non-blocking assignments, so every
    // branch sees the values from the start of the cycle. The arbitration
    // and the counter compares rely on that.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            step_cnt   <= '0;
            byte_cnt   <= '0;
            work_ready <= 1'b0;
            rd_ack     <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            busy       <= 1'b0;
            select     <= 1'b0;
            rd_clk     <= 1'b0;
            read       <= 8'h00;
            wr_start   <= 1'b0;
            wr_clk     <= 1'b0;
        end else begin
            work_ready <= 1'b0;
            rd_ack     <= 1'b0;

            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept_work) begin
                        work_ready <= 1'b1;
                        select     <= 1'b1;
                        busy       <= 1'b1;
                        read       <= work_data[7:0];
                        step_cnt   <= '0;
                        byte_cnt   <= '0;
                        state      <= W_SETUP;
                    end else if (accept_rd) begin
                        rd_ack   <= 1'b1;
                        select   <= 1'b1;
                        busy     <= 1'b1;
                        wr_start <= 1'b1;
                        step_cnt <= '0;
                        byte_cnt <= '0;
                        state    <= R_START;
                    end
                end

                // read is already stable. Count out the setup time, then
                // strobe.
                W_SETUP: begin
                    if (step_cnt == STEP_LAST) begin
                        step_cnt <= '0;
                        rd_clk   <= ~rd_clk;
                        state    <= W_STROBE;
                    end else begin
                        step_cnt <= step_cnt + 5'd1;
                    end
                end

                // Hold read after the toggle, then present the next byte.
                W_STROBE: begin
                    if (step_cnt == STEP_LAST) begin
                        step_cnt <= '0;
                        if (byte_cnt == IN_LAST) begin
                            read   <= 8'h00;
                            select <= 1'b0;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                            read     <= shreg[15:8];
                            state    <= W_SETUP;
                        end
                    end else begin
                        step_cnt <= step_cnt + 5'd1;
                    end
                end

                R_START: begin
                    if (step_cnt == START_LAST) begin
                        step_cnt <= '0;
                        wr_start <= 1'b0;
                        state    <= R_SETTLE;
                    end else begin
                        step_cnt <= step_cnt + 5'd1;
                    end
                end

                R_SETTLE: begin
                    if (step_cnt == SETTLE_LAST) begin
                        step_cnt <= '0;
                        state    <= R_SAMPLE;
                    end else begin
                        step_cnt <= step_cnt + 5'd1;
                    end
                end

                // New byte enters at the top. After OUT_BYTES captures, the
                // first byte received has shifted down to [7:0]. The last
                // capture does not advance the slave.
                R_SAMPLE: begin
                    res_data <= {write, res_data[OUT_W-1:8]};
                    if (byte_cnt == OUT_LAST) begin
                        res_valid <= 1'b1;
                        select    <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        byte_cnt <= byte_cnt + 6'd1;
                        wr_clk   <= ~wr_clk;
                        state    <= R_SETTLE;
                    end
                end

                default: begin
                    select <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ufm_host_link_master.sv
module tb_ufm_host_link_master;

    localparam int STEP      = 4;
    localparam int SETTLE    = 16;
    localparam int IN_BYTES  = 44;
    localparam int OUT_BYTES = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         work_valid;
    logic [351:0] work_data;
    logic         work_ready;
    logic         rd_req;
    logic         rd_ack;
    logic         res_valid;
    logic [127:0] res_data;
    logic         res_ready;
    logic         busy;
    logic         select;
    logic         rd_clk;
    logic [7:0]   read;
    logic         wr_start;
    logic         wr_clk;
    logic [7:0]   write;

    ufm_host_link_master #(
        .STEP(STEP), .SETTLE(SETTLE), .IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES)
    ) dut (
        .clk(clk), .reset(reset),
        .work_valid(work_valid), .work_data(work_data), .work_ready(work_ready),
        .rd_req(rd_req), .rd_ack(rd_ack),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .select(select),
        .rd_clk(rd_clk), .read(read),
        .wr_start(wr_start), .wr_clk(wr_clk), .write(write)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Link monitor and slave model. This block runs 1 ns after each rising
    // edge, so the test blocks on the falling edge always see updated counts.
    int         cyc = 0;
    int         busy_cycles = 0;
    int         wr_start_cycles = 0;
    int         work_ready_pulses = 0;
    int         rd_ack_pulses = 0;
    int         rd_toggles = 0;
    int         wr_toggles = 0;
    int         work_acc_cyc = 0;
    logic [7:0] rd_bytes[$];
    int         rd_times[$];
    logic [7:0] slave_bytes[16];
    int         slave_idx = 0;
    logic       prev_rd_clk = 1'b0;
    logic       prev_wr_clk = 1'b0;
    logic       prev_wr_start = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy === 1'b1) busy_cycles++;
            if (wr_start === 1'b1) wr_start_cycles++;
            if (work_ready === 1'b1) begin
                work_ready_pulses++;
                work_acc_cyc = cyc;
            end
            if (rd_ack === 1'b1) rd_ack_pulses++;
            if (rd_clk !== prev_rd_clk) begin
                rd_toggles++;
                rd_bytes.push_back(read);
                rd_times.push_back(cyc);
            end
            if (wr_start === 1'b1 && prev_wr_start !== 1'b1) slave_idx = 0;
            if (wr_clk !== prev_wr_clk) begin
                wr_toggles++;
                if (slave_idx < 15) slave_idx++;
            end
            write         = slave_bytes[slave_idx];
            prev_rd_clk   = rd_clk;
            prev_wr_clk   = wr_clk;
            prev_wr_start = wr_start;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [351:0] rand_work();
        logic [351:0] d;
        for (int i = 0; i < 11; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [15:0] out_vec();
        return {work_ready, rd_ack, res_valid, busy, select, rd_clk, read, wr_start, wr_clk};
    endfunction

    // Offer one work unit and check the whole byte stream against the unit.
    task automatic run_write(input string tag, input logic [351:0] data,
                             input logic [7:0] exp_first, input logic [7:0] exp_last);
        int n, b0, wr0, ws0, bad, sp_bad, sz;
        logic [7:0] first, last;
        rd_bytes.delete();
        rd_times.delete();
        b0 = busy_cycles; wr0 = work_ready_pulses; ws0 = wr_start_cycles;
        work_data  = data;
        work_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (work_ready !== 1'b1 && n < 100);
        check({tag, " accept"}, work_ready, 1);
        @(negedge clk);
        work_valid = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        check({tag, " done"}, busy, 0);
        sz = rd_bytes.size();
        check({tag, " toggles"}, sz, IN_BYTES);
        bad = 0;
        for (int k = 0; k < IN_BYTES; k++)
            if (k >= sz || rd_bytes[k] !== data[8*k +: 8]) bad++;
        check({tag, " byte errors"}, bad, 0);
        first = (sz > 0) ? rd_bytes[0] : 8'hxx;
        last  = (sz > 0) ? rd_bytes[sz-1] : 8'hxx;
        check({tag, " first byte"}, first, exp_first);
        check({tag, " last byte"}, last, exp_last);
        sp_bad = 0;
        if (sz == 0 || rd_times[0] - work_acc_cyc != STEP) sp_bad++;
        for (int k = 1; k < sz; k++)
            if (rd_times[k] - rd_times[k-1] != 2 * STEP) sp_bad++;
        check({tag, " strobe spacing"}, sp_bad, 0);
        check({tag, " busy cycles"}, busy_cycles - b0, 2 * STEP * IN_BYTES);
        check({tag, " ready pulses"}, work_ready_pulses - wr0, 1);
        check({tag, " no wr_start"}, wr_start_cycles - ws0, 0);
        check({tag, " idle read/select"}, {read, select}, 9'h000);
    endtask

    task automatic wait_res(input string tag);
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        check({tag, " res_valid"}, res_valid, 1);
    endtask

    task automatic consume(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, " res_valid cleared"}, res_valid, 0);
    endtask

    // Readback with slave_bytes preloaded by the caller.
    task automatic run_read(input string tag, input logic [127:0] exp, input bit do_consume);
        int n, wt0, ws0, ra0;
        wt0 = wr_toggles; ws0 = wr_start_cycles; ra0 = rd_ack_pulses;
        rd_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (rd_ack !== 1'b1 && n < 100);
        check({tag, " ack"}, rd_ack, 1);
        @(negedge clk);
        rd_req = 1'b0;
        wait_res(tag);
        check({tag, " res_data"}, res_data, exp);
        check({tag, " wr_clk toggles"}, wr_toggles - wt0, OUT_BYTES - 1);
        check({tag, " wr_start cycles"}, wr_start_cycles - ws0, 2 * STEP);
        check({tag, " ack pulses"}, rd_ack_pulses - ra0, 1);
        check({tag, " busy after"}, busy, 0);
        if (do_consume) consume(tag);
    endtask

    typedef struct {
        string        name;
        logic [351:0] data;
        logic [7:0]   first;
        logic [7:0]   last;
    } wvec_t;

    typedef struct {
        string        name;
        logic [7:0]   base;
        logic [127:0] exp;
    } rvec_t;

    initial begin
        wvec_t        wtab[3];
        rvec_t        rtab[2];
        logic [351:0] incr, d, a_data, b_data;
        logic [127:0] exp, held;
        int           n, bad, acks, ra0, ws0, t0, t1, sl, sz;

        for (int k = 0; k < IN_BYTES; k++) begin
            incr[8*k +: 8] = 8'(k + 1);
            d[8*k +: 8]    = 8'(255 - k);
        end
        wtab[0] = '{"wr incr", incr, 8'h01, 8'h2C};
        wtab[1] = '{"wr 5a", {44{8'h5A}}, 8'h5A, 8'h5A};
        wtab[2] = '{"wr down", d, 8'hFF, 8'hD4};
        rtab[0] = '{"rd a0", 8'hA0, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0};
        rtab[1] = '{"rd 10", 8'h10, 128'h1F1E1D1C1B1A19181716151413121110};

        reset = 1'b1; work_valid = 1'b0; work_data = '0; rd_req = 1'b0;
        res_ready = 1'b0; write = 8'h00;
        for (int k = 0; k < 16; k++) slave_bytes[k] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset outputs", out_vec(), 16'h0000);
        check("reset res_data", res_data, 128'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) run_write(wtab[i].name, wtab[i].data, wtab[i].first, wtab[i].last);

        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) slave_bytes[k] = 8'(rtab[i].base + 8'(k));
            run_read(rtab[i].name, rtab[i].exp, 1'b1);
        end

        // Result held: stays stable, and a second readback waits for res_ready.
        for (int k = 0; k < 16; k++) slave_bytes[k] = 8'(8'h30 + 8'(k));
        run_read("hold", 128'h3F3E3D3C3B3A39383736353433323130, 1'b0);
        held = res_data;
        rd_req = 1'b1;
        bad = 0; acks = 0;
        repeat (100) begin
            @(negedge clk);
            if (res_data !== held || res_valid !== 1'b1) bad++;
            if (rd_ack === 1'b1) acks++;
        end
        check("hold stable", bad, 0);
        check("hold no ack", acks, 0);
        for (int k = 0; k < 16; k++) slave_bytes[k] = 8'(8'h60 + 8'(k));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("hold ack after ready", rd_ack, 1);
        check("hold valid dropped", res_valid, 0);
        @(negedge clk);
        rd_req = 1'b0;
        wait_res("hold second");
        check("hold second res_data", res_data, 128'h6F6E6D6C6B6A69686766656463626160);
        consume("hold second");

        // Work and readback raised together: the write goes first.
        for (int k = 0; k < 16; k++) slave_bytes[k] = 8'(8'h50 + 8'(k));
        rd_bytes.delete(); rd_times.delete();
        ra0 = rd_ack_pulses; ws0 = wr_start_cycles;
        work_data = incr; work_valid = 1'b1; rd_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (work_ready !== 1'b1 && n < 100);
        check("both work first", work_ready, 1);
        check("both no early ack", rd_ack_pulses - ra0, 0);
        @(negedge clk);
        work_valid = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        check("both write done", busy, 0);
        check("both idle no ack yet", rd_ack, 0);
        check("both no wr_start during write", wr_start_cycles - ws0, 0);
        check("both write bytes", rd_bytes.size(), IN_BYTES);
        @(negedge clk);
        check("both ack after write", rd_ack, 1);
        rd_req = 1'b0;
        wait_res("both");
        check("both res_data", res_data, 128'h5F5E5D5C5B5A59585756555453525150);
        consume("both");

        // Reset in the middle of byte 20 of a write.
        work_data = rand_work(); work_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (work_ready !== 1'b1 && n < 100);
        @(negedge clk);
        work_valid = 1'b0;
        t0 = rd_toggles;
        n = 0;
        while (rd_toggles - t0 < 20 && n < 1000) begin @(negedge clk); n++; end
        check("abort reached byte 20", rd_toggles - t0, 20);
        reset = 1'b1;
        @(negedge clk);
        check("abort outputs zero", out_vec(), 16'h0000);
        check("abort res_data zero", res_data, 128'h0);
        reset = 1'b0;
        t1 = rd_toggles;
        repeat (50) @(negedge clk);
        check("abort no more strobes", rd_toggles - t1, 0);
        check("abort idle", busy, 0);
        run_write("post-reset", incr, 8'h01, 8'h2C);

        // Back-to-back work units.
        a_data = rand_work(); b_data = rand_work();
        rd_bytes.delete(); rd_times.delete();
        t0 = rd_toggles;
        work_data = a_data; work_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (work_ready !== 1'b1 && n < 100);
        @(negedge clk);
        work_data = b_data;
        sl = (select === 1'b0) ? 1 : 0;
        n = 0;
        while (work_ready !== 1'b1 && n < 1000) begin
            @(negedge clk); n++;
            if (select === 1'b0) sl++;
        end
        check("b2b second accept", work_ready, 1);
        check("b2b select gap", sl, 1);
        @(negedge clk);
        work_valid = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        check("b2b toggles", rd_toggles - t0, 2 * IN_BYTES);
        sz = rd_bytes.size();
        bad = 0;
        for (int k = 0; k < 2 * IN_BYTES; k++) begin
            if (k >= sz) bad++;
            else if (k < IN_BYTES && rd_bytes[k] !== a_data[8*k +: 8]) bad++;
            else if (k >= IN_BYTES && rd_bytes[k] !== b_data[8*(k-IN_BYTES) +: 8]) bad++;
        end
        check("b2b byte errors", bad, 0);

        // Randomized traffic against the byte-order model.
        for (int i = 0; i < 4; i++) begin
            d = rand_work();
            run_write($sformatf("rand wr %0d", i), d, d[7:0], d[351:344]);
        end
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 16; k++) begin
                slave_bytes[k] = 8'($urandom_range(0, 255));
                exp[8*k +: 8]  = slave_bytes[k];
            end
            run_read($sformatf("rand rd %0d", i), exp, 1'b1);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
